mem_waitstate: RTL and testbench

Parametrised, byte-enabled unified instruction/data memory for the multicycle MIPS datapath, with a request/ready handshake and a programmable number of wait states. The datapath FSM issues one access at a time and stalls until `ready`. An independent debug read port lets board switches inspect any word. Sits where the single-cycle-access memory sat, between the datapath's address/write-data muxes and the IR/MDR registers.

---
 rtl/mem_pkg.sv | 13 +
 rtl/mem_array.sv | 38 +++
 rtl/mem_waitstate.sv | 149 ++++++++++++++
 tb/tb_mem_waitstate.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared state encoding, byte-offset constants and index-width helper
package mem_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} mem_state_t;

  localparam int WORD_BYTES = 4;
  localparam int BYTE_OFS_W = 2;

  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/mem_array.sv
// rtl/mem_array.sv - DEPTH x DATA_W storage, byte-enabled sync write, combinational reads
// Second (debug) read port exists only when MEM_DBG_PORT_EN is defined.
module mem_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int IDX_W  = 10
) (
  input  logic                clk,
  input  logic                wr_en,
  input  logic [IDX_W-1:0]    wr_idx,
  input  logic [DATA_W/8-1:0] wr_be,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [IDX_W-1:0]    rd_idx,
  output logic [DATA_W-1:0]   rd_data
`ifdef MEM_DBG_PORT_EN
  ,
  input  logic [IDX_W-1:0]    dbg_idx,
  output logic [DATA_W-1:0]   dbg_data
`endif
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < DATA_W/8; b++) begin
        if (wr_be[b]) r_mem[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
      end
    end
  end

  assign rd_data = r_mem[rd_idx];

`ifdef MEM_DBG_PORT_EN
  assign dbg_data = r_mem[dbg_idx];
`endif

endmodule

// File: rtl/mem_waitstate.sv
// rtl/mem_waitstate.sv - unified memory with req/ready handshake and WAIT_CYCLES wait states
// Optional debug read port enabled by MEM_DBG_PORT_EN; otherwise out_data is 0.
module mem_waitstate
  import mem_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 1,
  parameter int DBG_ADDR_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic                  we,
  input  logic [DATA_W/8-1:0]   be,
  input  logic [31:0]           addr,
  input  logic [DATA_W-1:0]     w_data,
  output logic [DATA_W-1:0]     mem_data,
  output logic                  ready,
  output logic                  busy,
  output logic                  err,
  input  logic [DBG_ADDR_W-1:0] sw_addr,
  output logic [DATA_W-1:0]     out_data
);

  localparam int         IDX_W    = idx_width(DEPTH);
  localparam int         BE_W     = DATA_W / 8;
  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES);

  mem_state_t        r_state, w_next_state;
  logic [3:0]        r_cnt, w_cnt_next;
  logic              r_we;
  logic [BE_W-1:0]   r_be;
  logic [IDX_W-1:0]  r_idx;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_mem_data;
  logic              r_ready, r_err;

  logic              w_accept, w_reject, w_do_access, w_addr_ok, w_wr_en;
  logic [31:0]       w_addr_hi;
  logic [DATA_W-1:0] w_rd_data;

  // Any bit above the word index makes the address fall outside the array.
  assign w_addr_hi = addr >> (BYTE_OFS_W + IDX_W);
  assign w_addr_ok = (addr[BYTE_OFS_W-1:0] == '0) && (w_addr_hi == '0);

  always_comb begin
    w_next_state = r_state;
    w_cnt_next   = r_cnt;
    w_accept     = 1'b0;
    w_reject     = 1'b0;
    w_do_access  = 1'b0;
    case (r_state)
      IDLE: begin
        if (req) begin
          if (w_addr_ok) begin
            w_accept     = 1'b1;
            w_cnt_next   = CNT_INIT;
            w_next_state = (CNT_INIT == 4'd0) ? DONE : WAIT;
          end else begin
            w_reject = 1'b1;
          end
        end
      end
      WAIT: begin
        w_cnt_next = r_cnt - 4'd1;
        if (w_cnt_next == 4'd0) w_next_state = DONE;
      end
      DONE: begin
        w_do_access  = 1'b1;
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_cnt_next;
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_we    <= we;
      r_be    <= be;
      r_idx   <= addr[BYTE_OFS_W +: IDX_W];
      r_wdata <= w_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ready    <= 1'b0;
      r_err      <= 1'b0;
      r_mem_data <= '0;
    end else begin
      r_ready <= w_do_access;
      r_err   <= w_reject;
      if (w_do_access && !r_we) r_mem_data <= w_rd_data;
    end
  end

  // Reset arriving on the DONE edge must still discard the pending write.
  assign w_wr_en = w_do_access && r_we && !rst;

`ifdef MEM_DBG_PORT_EN
  logic [31:0]       w_dbg_ext;
  logic [IDX_W-1:0]  w_dbg_idx;
  logic [DATA_W-1:0] w_dbg_data;

  assign w_dbg_ext = 32'(sw_addr);
  assign w_dbg_idx = w_dbg_ext[IDX_W-1:0];
  assign out_data  = (w_dbg_ext < 32'(DEPTH)) ? w_dbg_data : '0;
`else
  logic w_unused_sw_addr;
  assign w_unused_sw_addr = ^sw_addr;
  assign out_data         = '0;
`endif

  mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk     (clk),
    .wr_en   (w_wr_en),
    .wr_idx  (r_idx),
    .wr_be   (r_be),
    .wr_data (r_wdata),
    .rd_idx  (r_idx),
    .rd_data (w_rd_data)
`ifdef MEM_DBG_PORT_EN
    ,
    .dbg_idx (w_dbg_idx),
    .dbg_data(w_dbg_data)
`endif
  );

  assign mem_data = r_mem_data;
  assign ready    = r_ready;
  assign err      = r_err;
  assign busy     = (r_state != IDLE);

endmodule

// File: tb/tb_mem_waitstate.sv
// tb/tb_mem_waitstate.sv - randomized self-checking bench for mem_waitstate against a word-array model
module tb_mem_waitstate;

  localparam int WC = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, we;
  logic [3:0]  be;
  logic [31:0] addr, w_data, mem_data, out_data;
  logic        ready, busy, err;
  logic [7:0]  sw_addr;

  logic        z_req, z_we;
  logic [3:0]  z_be;
  logic [31:0] z_addr, z_wdata, z_mem_data, z_out;
  logic        z_ready, z_busy, z_err;
  logic [7:0]  z_sw;

  int errors = 0;
  int checks = 0;

  logic [31:0] model_mem [1024];
  logic [31:0] trace_dbg [16];

  always #5 clk = ~clk;

  mem_waitstate #(.DATA_W(32), .DEPTH(1024), .WAIT_CYCLES(WC), .DBG_ADDR_W(8)) u_dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .be(be), .addr(addr), .w_data(w_data),
    .mem_data(mem_data), .ready(ready), .busy(busy), .err(err),
    .sw_addr(sw_addr), .out_data(out_data)
  );

  mem_waitstate #(.DATA_W(32), .DEPTH(1024), .WAIT_CYCLES(0), .DBG_ADDR_W(8)) u_dut0 (
    .clk(clk), .rst(rst), .req(z_req), .we(z_we), .be(z_be), .addr(z_addr), .w_data(z_wdata),
    .mem_data(z_mem_data), .ready(z_ready), .busy(z_busy), .err(z_err),
    .sw_addr(z_sw), .out_data(z_out)
  );

  function automatic void model_write(input int idx, input logic [3:0] mbe, input logic [31:0] d);
    for (int b = 0; b < 4; b++)
      if (mbe[b]) model_mem[idx][b*8 +: 8] = d[b*8 +: 8];
  endfunction

  task automatic run_access(input logic iwe, input logic [3:0] ibe, input logic [31:0] iaddr,
                            input logic [31:0] idata, input bit toggle,
                            output int lat, output int err_i, output logic busy0,
                            output logic [31:0] rd);
    lat = -1; err_i = -1; busy0 = 1'b0; rd = '0;
    @(negedge clk);
    req = 1'b1; we = iwe; be = ibe; addr = iaddr; w_data = idata;
    for (int i = 0; i < WC + 5; i++) begin
      @(negedge clk);
      if (i == 0) busy0 = busy;
      if (err && err_i < 0) err_i = i;
      if (ready && lat < 0) begin lat = i; rd = mem_data; end
      trace_dbg[i] = out_data;
      if (toggle && i <= WC) begin
        req = 1'($urandom_range(0, 1)); we = 1'($urandom_range(0, 1));
        be = 4'($urandom); addr = $urandom; w_data = $urandom;
      end else begin
        req = 1'b0;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; req = 0; we = 0; be = 0; addr = 0; w_data = 0; sw_addr = 0;
    z_req = 0; z_we = 0; z_be = 0; z_addr = 0; z_wdata = 0; z_sw = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", ready); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (mem_data !== 32'h0) begin errors++; $display("FAIL reset_mem_data got %h exp 0", mem_data); end
    checks++; if (z_mem_data !== 32'h0) begin errors++; $display("FAIL reset_z_mem_data got %h exp 0", z_mem_data); end
    rst = 1'b0;
  endtask

  task automatic preload;
    int lat, ei; logic b0; logic [31:0] rd, d;
    for (int w = 0; w < 16; w++) begin
      d = $urandom;
      run_access(1'b1, 4'hF, 32'(w * 4), d, 1'b0, lat, ei, b0, rd);
      model_write(w, 4'hF, d);
    end
  endtask

  task automatic test_basic;
    int lat, ei; logic b0; logic [31:0] rd;
    run_access(1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 1'b0, lat, ei, b0, rd);
    model_write(4, 4'hF, 32'hDEADBEEF);
    checks++; if (lat !== WC + 1) begin errors++; $display("FAIL basic_wr_latency got %0d exp %0d", lat, WC + 1); end
    checks++; if (b0 !== 1'b1) begin errors++; $display("FAIL basic_busy got %b exp 1", b0); end
    run_access(1'b0, 4'h0, 32'h10, $urandom, 1'b0, lat, ei, b0, rd);
    checks++; if (lat !== WC + 1) begin errors++; $display("FAIL basic_rd_latency got %0d exp %0d", lat, WC + 1); end
    checks++; if (rd !== model_mem[4]) begin errors++; $display("FAIL basic_rd_data got %h exp %h", rd, model_mem[4]); end
    checks++; if (mem_data !== model_mem[4]) begin errors++; $display("FAIL basic_rd_hold got %h exp %h", mem_data, model_mem[4]); end
  endtask

  task automatic test_byte_enable;
    int lat, ei; logic b0; logic [31:0] rd;
    run_access(1'b1, 4'hF, 32'h20, 32'h11223344, 1'b0, lat, ei, b0, rd);
    model_write(8, 4'hF, 32'h11223344);
    run_access(1'b1, 4'b0101, 32'h20, 32'hAABBCCDD, 1'b0, lat, ei, b0, rd);
    model_write(8, 4'b0101, 32'hAABBCCDD);
    run_access(1'b0, 4'hF, 32'h20, 32'h0, 1'b0, lat, ei, b0, rd);
    checks++; if (rd !== 32'h11BB33DD) begin errors++; $display("FAIL byte_enable got %h exp 11bb33dd", rd); end
    checks++; if (rd !== model_mem[8]) begin errors++; $display("FAIL byte_enable_model got %h exp %h", rd, model_mem[8]); end
  endtask

  task automatic test_error;
    int lat, ei; logic b0; logic [31:0] rd;
    logic [31:0] bad [2];
    bad[0] = 32'h0000_0002; bad[1] = 32'h0000_1000;
    for (int k = 0; k < 2; k++) begin
      run_access(1'b1, 4'hF, bad[k], 32'hFFFF_FFFF, 1'b0, lat, ei, b0, rd);
      checks++; if (ei !== 0) begin errors++; $display("FAIL err_pulse addr=%h got idx %0d exp 0", bad[k], ei); end
      checks++; if (b0 !== 1'b0) begin errors++; $display("FAIL err_busy addr=%h got %b exp 0", bad[k], b0); end
      checks++; if (lat !== -1) begin errors++; $display("FAIL err_no_ready addr=%h got %0d exp -1", bad[k], lat); end
    end
    run_access(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, lat, ei, b0, rd);
    checks++; if (rd !== model_mem[0]) begin errors++; $display("FAIL err_mem_untouched got %h exp %h", rd, model_mem[0]); end
  endtask

  task automatic test_toggle;
    int lat, ei; logic b0; logic [31:0] rd, d;
    d = $urandom;
    run_access(1'b1, 4'hF, 32'h14, d, 1'b1, lat, ei, b0, rd);
    model_write(5, 4'hF, d);
    checks++; if (lat !== WC + 1) begin errors++; $display("FAIL toggle_latency got %0d exp %0d", lat, WC + 1); end
    run_access(1'b0, 4'h0, 32'h14, 32'h0, 1'b0, lat, ei, b0, rd);
    checks++; if (rd !== model_mem[5]) begin errors++; $display("FAIL toggle_latched_data got %h exp %h", rd, model_mem[5]); end
  endtask

  task automatic test_back_to_back;
    int rdy_at [$];
    logic [31:0] rdy_val [$];
    @(negedge clk);
    req = 1'b1; we = 1'b0; be = 4'h0; addr = 32'h10;
    for (int i = 0; i < 3 * (WC + 2); i++) begin
      @(negedge clk);
      if (ready) begin rdy_at.push_back(i); rdy_val.push_back(mem_data); end
    end
    req = 1'b0;
    repeat (WC + 3) @(negedge clk);
    checks++; if (rdy_at.size() !== 3) begin errors++; $display("FAIL b2b_count got %0d exp 3", rdy_at.size()); end
    for (int k = 0; k + 1 < rdy_at.size(); k++) begin
      checks++;
      if (rdy_at[k+1] - rdy_at[k] !== WC + 2) begin
        errors++; $display("FAIL b2b_spacing got %0d exp %0d", rdy_at[k+1] - rdy_at[k], WC + 2);
      end
    end
    for (int k = 0; k < rdy_val.size(); k++) begin
      checks++; if (rdy_val[k] !== model_mem[4]) begin errors++; $display("FAIL b2b_data got %h exp %h", rdy_val[k], model_mem[4]); end
    end
  endtask

  task automatic test_reset_mid;
    int lat, ei, seen; logic b0; logic [31:0] rd;
    seen = 0;
    @(negedge clk);
    req = 1'b1; we = 1'b1; be = 4'hF; addr = 32'hC; w_data = 32'h5555_5555;
    @(negedge clk);
    if (ready) seen++;
    rst = 1'b1; req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b exp 0", busy); end
    for (int i = 0; i < WC + 4; i++) begin
      if (ready) seen++;
      @(negedge clk);
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL rst_mid_ready got %0d pulses exp 0", seen); end
    run_access(1'b0, 4'h0, 32'hC, 32'h0, 1'b0, lat, ei, b0, rd);
    checks++; if (rd !== model_mem[3]) begin errors++; $display("FAIL rst_mid_word3 got %h exp %h", rd, model_mem[3]); end
  endtask

  task automatic test_debug;
    int lat, ei; logic b0; logic [31:0] rd, old_v, exp_old, exp_new;
    old_v = model_mem[3];
    sw_addr = 8'd3;
    run_access(1'b1, 4'hF, 32'hC, 32'hCAFEF00D, 1'b0, lat, ei, b0, rd);
    model_write(3, 4'hF, 32'hCAFEF00D);
`ifdef MEM_DBG_PORT_EN
    exp_old = old_v; exp_new = 32'hCAFEF00D;
`else
    exp_old = 32'h0; exp_new = 32'h0;
`endif
    checks++; if (trace_dbg[WC] !== exp_old) begin errors++; $display("FAIL dbg_old_in_done got %h exp %h", trace_dbg[WC], exp_old); end
    checks++; if (trace_dbg[WC+2] !== exp_new) begin errors++; $display("FAIL dbg_new got %h exp %h", trace_dbg[WC+2], exp_new); end
    checks++; if (trace_dbg[WC+3] !== exp_new) begin errors++; $display("FAIL dbg_new_hold got %h exp %h", trace_dbg[WC+3], exp_new); end
  endtask

  task automatic test_zero_wait;
    int lat; logic b0; logic [31:0] rd, d;
    logic iwe;
    d = $urandom;
    for (int op = 0; op < 2; op++) begin
      iwe = (op == 0);
      lat = -1; b0 = 1'b0; rd = '0;
      @(negedge clk);
      z_req = 1'b1; z_we = iwe; z_be = 4'hF; z_addr = 32'h1C; z_wdata = d;
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        if (i == 0) b0 = z_busy;
        if (z_ready && lat < 0) begin lat = i; rd = z_mem_data; end
        z_req = 1'b0;
      end
      checks++; if (lat !== 1) begin errors++; $display("FAIL zero_wait_latency op=%0d got %0d exp 1", op, lat); end
      checks++; if (b0 !== 1'b1) begin errors++; $display("FAIL zero_wait_busy op=%0d got %b exp 1", op, b0); end
    end
    checks++; if (rd !== d) begin errors++; $display("FAIL zero_wait_data got %h exp %h", rd, d); end
  endtask

  task automatic test_random;
    int lat, ei, idx; logic b0; logic [31:0] rd, a, d; logic [3:0] rbe; logic rwe, valid;
    for (int n = 0; n < 40; n++) begin
      idx = $urandom_range(0, 15);
      valid = ($urandom_range(0, 4) != 0);
      if (valid) a = 32'(idx * 4);
      else if ($urandom_range(0, 1) == 0) a = 32'(idx * 4) | 32'($urandom_range(1, 3));
      else a = 32'(idx * 4) | (32'h1 << $urandom_range(12, 31));
      rwe = 1'($urandom_range(0, 1)); rbe = 4'($urandom); d = $urandom;
      run_access(rwe, rbe, a, d, 1'b0, lat, ei, b0, rd);
      if (!valid) begin
        checks++; if (ei !== 0 || lat !== -1) begin errors++; $display("FAIL rand_reject addr=%h err_idx=%0d lat=%0d exp 0/-1", a, ei, lat); end
      end else begin
        checks++; if (lat !== WC + 1 || ei !== -1) begin errors++; $display("FAIL rand_latency addr=%h lat=%0d err_idx=%0d exp %0d/-1", a, lat, ei, WC + 1); end
        if (rwe) model_write(idx, rbe, d);
        else begin
          checks++; if (rd !== model_mem[idx]) begin errors++; $display("FAIL rand_read addr=%h got %h exp %h", a, rd, model_mem[idx]); end
        end
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    preload();
    test_basic();
    test_byte_enable();
    test_error();
    test_toggle();
    test_back_to_back();
    test_reset_mid();
    test_debug();
    test_zero_wait();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
